// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, host command bytes and
// the parity rule used on the wire.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE,
    ERROR
  } state_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data pins, with a
// falling-edge strobe on the synchronised clock. The receiver can reuse it.
module ps2_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ps2clk,
  input  logic i_ps2dat,
  output logic o_clk_sync,
  output logic o_dat_sync,
  output logic o_clk_fall
);

  logic [1:0] r_clk_meta;
  logic [1:0] r_dat_meta;
  logic       r_clk_prev;

  // Idle PS/2 lines float high, so the chain resets to 1 and no false edge
  // appears when reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta <= 2'b11;
      r_dat_meta <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so the chain really is two stages deep, not one.
      r_clk_meta <= {r_clk_meta[0], i_ps2clk};
      r_dat_meta <= {r_dat_meta[0], i_ps2dat};
      r_clk_prev <= r_clk_meta[1];
    end
  end

  assign o_clk_sync = r_clk_meta[1];
  assign o_dat_sync = r_dat_meta[1];
  assign o_clk_fall = r_clk_prev & ~r_clk_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first,
// odd parity, stop, then device ack. All outputs come straight from flops.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2clk,
  input  logic       ps2dat,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  logic w_clk_s, w_dat_s, w_clk_fall;

  ps2_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_ps2clk   (ps2clk),
    .i_ps2dat   (ps2dat),
    .o_clk_sync (w_clk_s),
    .o_dat_sync (w_dat_s),
    .o_clk_fall (w_clk_fall)
  );

  state_t             r_state, w_state_nxt;
  logic [INH_W-1:0]   r_inh_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [3:0]         r_bit_cnt;
  logic [9:0]         r_shift;
  logic r_ready, r_clk_oe, r_dat_oe, r_done, r_error, r_busy;
  logic w_timeout, w_inh_last, w_present;
  logic w_ready_d, w_clk_oe_d, w_dat_oe_d, w_done_d, w_error_d, w_busy_d;

  // Expiry fires one cycle early so ERROR is entered exactly TIMEOUT_CYCLES
  // cycles after the clock line is released.
  assign w_timeout  = (r_to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
  assign w_inh_last = (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  assign w_present  = w_clk_fall && !w_timeout &&
                      ((r_state == START) || (r_state == SHIFT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: a default before the case keeps this purely combinational; any
    // path that leaves w_state_nxt unassigned would infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:      if (tx_valid) w_state_nxt = INHIBIT;
      INHIBIT:   if (w_inh_last) w_state_nxt = START;
      START:     if (w_timeout) w_state_nxt = ERROR;
                 else if (w_clk_fall) w_state_nxt = SHIFT;
      SHIFT:     if (w_timeout) w_state_nxt = ERROR;
                 else if (w_clk_fall && r_bit_cnt == 4'd9) w_state_nxt = ACK;
      ACK:       if (w_timeout) w_state_nxt = ERROR;
                 else if (w_clk_fall) w_state_nxt = w_dat_s ? ERROR : WAIT_IDLE;
      WAIT_IDLE: if (w_timeout) w_state_nxt = ERROR;
                 else if (w_clk_s && w_dat_s) w_state_nxt = IDLE;
      ERROR:     w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state and
  // registered below so nothing on the pins depends combinationally on inputs.
  always_comb begin
    w_ready_d  = (w_state_nxt == IDLE);
    w_busy_d   = (w_state_nxt != IDLE);
    w_clk_oe_d = (w_state_nxt == INHIBIT);
    w_done_d   = (r_state == WAIT_IDLE) && (w_state_nxt == IDLE);
    w_error_d  = (w_state_nxt == ERROR);
    w_dat_oe_d = 1'b0;
    unique case (w_state_nxt)
      INHIBIT:    w_dat_oe_d = (r_state == INHIBIT) &&
                               (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 2));
      START:      w_dat_oe_d = 1'b1;
      SHIFT, ACK: w_dat_oe_d = w_present ? ~r_shift[0] : r_dat_oe;
      default:    w_dat_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ready   <= 1'b1;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ready  <= w_ready_d;
      r_clk_oe <= w_clk_oe_d;
      r_dat_oe <= w_dat_oe_d;
      r_done   <= w_done_d;
      r_error  <= w_error_d;
      r_busy   <= w_busy_d;
      unique case (r_state)
        IDLE: begin
          r_inh_cnt <= '0;
          r_to_cnt  <= '0;
          r_bit_cnt <= '0;
          if (tx_valid) r_shift <= {1'b1, odd_parity(tx_data), tx_data};
        end
        INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + INH_W'(1);
          r_to_cnt  <= '0;
        end
        default: begin
          if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_present) begin
            r_shift   <= {1'b0, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign tx_ready  = r_ready;
  assign ps2clk_oe = r_clk_oe;
  assign ps2dat_oe = r_dat_oe;
  assign tx_done   = r_done;
  assign tx_error  = r_error;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: the bench thread itself plays the keyboard, clocking
// frames out of the host and comparing them with frames built from the byte.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 2500;
  localparam int TO  = 3000;
  localparam int HP  = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2clk, ps2dat;
  logic       tx_ready, ps2clk_oe, ps2dat_oe, tx_done, tx_error, busy;

  int  errors = 0;
  int  checks = 0;
  int  done_seen = 0;
  int  err_seen = 0;
  int  both_seen = 0;
  bit  scramble = 1'b0;

  assign ps2clk = ~(ps2clk_oe | dev_clk_low);
  assign ps2dat = ~(ps2dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .busy      (busy)
  );

  // Expected wire frame: d0..d7, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i];
    f[8] = ($countones(b) % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic cyc();
    @(negedge clk);
    if (tx_done === 1'b1) done_seen++;
    if (tx_error === 1'b1) err_seen++;
    if (tx_done === 1'b1 && tx_error === 1'b1) both_seen++;
    if (scramble) tx_data = 8'($urandom);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < TO + 500) begin cyc(); n++; end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL wait_ready: tx_ready=%b required 1", tx_ready);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    wait_ready();
    tx_data = b; tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
  endtask

  // Waits for the inhibit window and counts how long ps2clk_oe stays high.
  task automatic measure_inhibit(output int len, output logic start_bit);
    int n = 0;
    while (ps2clk_oe !== 1'b1 && n < 100) begin cyc(); n++; end
    len = 0;
    while (ps2clk_oe === 1'b1 && len < INH + 100) begin len++; cyc(); end
    start_bit = ps2dat_oe;
  endtask

  task automatic device_clock(input int edges, input bit ack, output logic [9:0] bits);
    bits = '0;
    repeat (HP) cyc();
    for (int e = 1; e <= edges; e++) begin
      if (e == 11 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HP) cyc();
      dev_clk_low = 1'b0;
      if (e <= 10) bits[e-1] = ps2dat;
      repeat (HP) cyc();
      if (e == 11) dev_dat_low = 1'b0;
    end
  endtask

  task automatic run_transfer(input logic [7:0] b, input bit ack, output int len,
                              output logic start_bit, output logic [9:0] bits);
    start_tx(b);
    measure_inhibit(len, start_bit);
    device_clock(11, ack, bits);
    wait_ready();
  endtask

  task automatic test_reset();
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    checks++; if (ps2clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2clk_oe); end
    checks++; if (ps2dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b want 0", ps2dat_oe); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done); end
    checks++; if (tx_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", tx_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_led_cmd();
    int len; logic sb; logic [9:0] bits;
    done_seen = 0; err_seen = 0;
    run_transfer(CMD_SET_LEDS, 1'b1, len, sb, bits);
    checks++; if (len != INH) begin errors++; $display("FAIL inhibit_len: got %0d want %0d", len, INH); end
    checks++; if (sb !== 1'b1) begin errors++; $display("FAIL start_bit: dat_oe=%b want 1", sb); end
    checks++; if (bits !== ref_frame(CMD_SET_LEDS)) begin errors++; $display("FAIL led_frame: got %b want %b", bits, ref_frame(CMD_SET_LEDS)); end
    checks++; if (done_seen != 1) begin errors++; $display("FAIL led_done: pulses=%0d want 1", done_seen); end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL led_error: pulses=%0d want 0", err_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL led_busy: got %b want 0", busy); end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [6];
    int len; logic sb; logic [9:0] bits;
    bytes[0] = CMD_ENABLE; bytes[1] = 8'h00; bytes[2] = CMD_RESET;
    for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      done_seen = 0; err_seen = 0;
      run_transfer(bytes[i], 1'b1, len, sb, bits);
      checks++; if (bits !== ref_frame(bytes[i])) begin errors++; $display("FAIL frame_%02h: got %b want %b", bytes[i], bits, ref_frame(bytes[i])); end
      checks++; if (done_seen != 1 || err_seen != 0) begin errors++; $display("FAIL done_%02h: done=%0d error=%0d want 1/0", bytes[i], done_seen, err_seen); end
    end
  endtask

  task automatic test_timeout();
    int len, k; logic sb;
    done_seen = 0; err_seen = 0;
    start_tx(CMD_ENABLE);
    measure_inhibit(len, sb);
    k = 0;
    while (tx_error !== 1'b1 && k < TO + 50) begin cyc(); k++; end
    checks++; if (k != TO) begin errors++; $display("FAIL timeout_delay: got %0d cycles want %0d", k, TO); end
    checks++; if (ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0) begin errors++; $display("FAIL timeout_release: clk_oe=%b dat_oe=%b want 0/0", ps2clk_oe, ps2dat_oe); end
    cyc();
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b want 1", tx_ready); end
    checks++; if (done_seen != 0 || err_seen != 1) begin errors++; $display("FAIL timeout_pulses: done=%0d error=%0d want 0/1", done_seen, err_seen); end
  endtask

  task automatic test_no_ack();
    int len; logic sb; logic [9:0] bits;
    logic [7:0] b = 8'($urandom);
    done_seen = 0; err_seen = 0;
    run_transfer(b, 1'b0, len, sb, bits);
    checks++; if (bits !== ref_frame(b)) begin errors++; $display("FAIL noack_frame: got %b want %b", bits, ref_frame(b)); end
    checks++; if (done_seen != 0 || err_seen != 1) begin errors++; $display("FAIL noack_pulses: done=%0d error=%0d want 0/1", done_seen, err_seen); end
  endtask

  task automatic test_reset_mid();
    int len; logic sb; logic [9:0] bits;
    done_seen = 0; err_seen = 0;
    start_tx(8'($urandom));
    measure_inhibit(len, sb);
    device_clock(4, 1'b1, bits);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (ps2clk_oe !== 1'b0 || ps2dat_oe !== 1'b0) begin errors++; $display("FAIL mid_release: clk_oe=%b dat_oe=%b want 0/0", ps2clk_oe, ps2dat_oe); end
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    checks++; if (done_seen != 0 || err_seen != 0) begin errors++; $display("FAIL mid_pulses: done=%0d error=%0d want 0/0", done_seen, err_seen); end
    run_transfer(CMD_RESET, 1'b1, len, sb, bits);
    checks++; if (bits !== ref_frame(CMD_RESET) || done_seen != 1) begin errors++; $display("FAIL mid_recover: frame=%b done=%0d want %b/1", bits, done_seen, ref_frame(CMD_RESET)); end
  endtask

  task automatic test_back_to_back();
    int len; logic sb; logic [9:0] bits_a, bits_b;
    logic [7:0] a = 8'($urandom);
    logic [7:0] b = ~a;
    done_seen = 0; err_seen = 0;
    wait_ready();
    tx_data = a; tx_valid = 1'b1; scramble = 1'b1;
    cyc();
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b want 0", tx_ready); end
    measure_inhibit(len, sb);
    device_clock(11, 1'b1, bits_a);
    scramble = 1'b0; tx_data = b;
    wait_ready();
    cyc();
    tx_valid = 1'b0;
    measure_inhibit(len, sb);
    device_clock(11, 1'b1, bits_b);
    wait_ready();
    checks++; if (bits_a !== ref_frame(a)) begin errors++; $display("FAIL b2b_first: got %b want %b", bits_a, ref_frame(a)); end
    checks++; if (bits_b !== ref_frame(b)) begin errors++; $display("FAIL b2b_second: got %b want %b", bits_b, ref_frame(b)); end
    checks++; if (len != INH) begin errors++; $display("FAIL b2b_inhibit: got %0d want %0d", len, INH); end
    checks++; if (done_seen != 2) begin errors++; $display("FAIL b2b_done: pulses=%0d want 2", done_seen); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (3) cyc();
    test_reset();
    test_led_cmd();
    test_parity();
    test_timeout();
    test_no_ack();
    test_reset_mid();
    test_back_to_back();
    checks++; if (both_seen != 0) begin errors++; $display("FAIL done_and_error: coincident=%0d want 0", both_seen); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes such as LED set (0xED), reset (0xFF) and enable (0xF4) to the keyboard whose scan codes the existing ps2 receiver decodes into the Z88 key matrix. It drives the open-collector ps2clk/ps2dat lines through active-high pull-low enables. It runs in the master-clock domain, alongside the receiver, on the same two pins.

Parameters:
INHIBIT_CYCLES, 2500, clk cycles ps2clk is held low before the start bit (100 us at 25 MHz)
TIMEOUT_CYCLES, 375000, clk cycles allowed from clock release to ack/idle (15 ms at 25 MHz)

Ports:
clk  input  1  master clock
reset_n  input  1  asynchronous active-low reset
ps2clk  input  1  raw PS/2 clock pin state (asynchronous)
ps2dat  input  1  raw PS/2 data pin state (asynchronous)
tx_data  input  8  byte to transmit
tx_valid  input  1  request; accepted when tx_ready=1
tx_ready  output  1  idle, can accept a byte
ps2clk_oe  output  1  1 = pull ps2clk low
ps2dat_oe  output  1  1 = pull ps2dat low
tx_done  output  1  one-cycle pulse: byte acknowledged by device
tx_error  output  1  one-cycle pulse: timeout or missing ack
busy  output  1  transfer in progress; receiver ignores the line while set

Behaviour:
- Reset: tx_ready=1, ps2clk_oe=0, ps2dat_oe=0, tx_done=0, tx_error=0, busy=0, state IDLE, counters 0.
- Synchronisation: ps2clk and ps2dat each pass through 2 flops. A falling edge is synced clk 1→0 against a registered copy. Edge-detect latency is 3 clk from the pin.
- Handshake: transfer accepted on the cycle tx_valid & tx_ready. tx_data is latched into shift[7:0], parity = ~^tx_data (odd). tx_ready drops the next cycle. tx_valid while busy is ignored.
- IDLE: tx_ready=1. On accept → INHIBIT, count=0.
- INHIBIT: ps2clk_oe=1, busy=1. After INHIBIT_CYCLES cycles, ps2dat_oe=1 (start bit). The following cycle ps2clk_oe=0 → START, timeout counter cleared.
- START: ps2dat_oe=1, bit index=0. On a falling edge, present d0 → SHIFT.
- SHIFT: on each falling edge, set ps2dat_oe = ~bit. Order is d0..d7 (LSB first), then parity, then stop.
  - Stop bit = release (ps2dat_oe=0).
  - Edges 1–8 present d0–d7, edge 9 presents parity, edge 10 presents stop → ACK.
- ACK: on the 11th falling edge, sample synced ps2dat.
  - 0 → WAIT_IDLE.
  - 1 → ERROR.
- WAIT_IDLE: wait for synced ps2clk=1 and ps2dat=1 → pulse tx_done=1 for one cycle → IDLE.
- ERROR: pulse tx_error=1 for one cycle, both oe=0 → IDLE.
- Timeout: a counter runs from START through WAIT_IDLE. When it reaches TIMEOUT_CYCLES → ERROR, which releases both lines. The counter saturates and never wraps.
- tx_done and tx_error never assert in the same cycle.
- ps2clk_oe is never asserted outside INHIBIT.
- Counter widths are $clog2 of the respective parameter +1.
- Asynchronous reset mid-transfer: both lines released immediately, no done/error pulse.
- A falling edge arriving in the same cycle as timeout expiry: timeout wins.
- Outputs are all registered, with no combinational path from ps2 inputs to outputs.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, ERROR)
  - command constants CMD_RESET=8'hFF, CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4
  - ack byte 8'hFA
- Sub-module ps2_sync: 2-flop synchroniser plus falling-edge detect for clk/dat. It is reusable by the receiver.

Test Plan:
- Send 0xED with a device model clocking at a 60 us period, ack driven low → ps2clk_oe high for exactly 2500 cycles. Data bits observed at device rising edges are 1,0,1,1,0,1,1,1, then parity 1 and stop 1. tx_done pulses once, tx_ready returns to 1.
- Send 0xF4 → parity bit 0. Send 0x00 → parity 1. Send 0xFF → parity 1. All complete with tx_done.
- Device never clocks after release → tx_error pulses exactly TIMEOUT_CYCLES cycles after clock release, both oe=0, tx_ready=1.
- Device leaves data high on the 11th edge (no ack) → tx_error pulse, no tx_done.
- reset_n asserted after the 4th falling edge → oe outputs 0 in the same cycle with no pulse. After release, a new 0xFF transfer completes normally.
- tx_valid held high with a changing tx_data during a transfer → only the first byte is sent. The second is accepted only after tx_ready=1.
